hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/hex_display_scanner_if.sv | 24 ++
 rtl/hex_display_scanner.sv | 142 ++++++++++++++
 tb/tb_hex_display_scanner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: load/blank controls in, digit drive out.
// The scanner takes the slave side; whoever feeds it takes the master side.
interface hex_display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank;
   logic [6:0]              seg;
   logic                    dot;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (
      output load, value, dp_in, blank,
      input  seg, dot, an, frame_done
   );

   modport slave (
      input  load, value, dp_in, blank,
      output seg, dot, an, frame_done
   );
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multiplexed 7-segment hex driver, frame-buffered loads.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module hex_display_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input logic                  clk,
   input logic                  rst,
   hex_display_scanner_if.slave bus
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [VW-1:0]         act_val;
   logic [VW-1:0]         pend_val;
   logic [NUM_DIGITS-1:0] act_dp;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic                  pend;
   logic                  tc;
   logic                  wrap;
   logic [3:0]            nib;
   logic                  dp_sel;
   logic                  dark;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic [6:0]            seg_q;
   logic                  dot_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  fd_q;

   assign tc   = (presc == P_LAST);
   assign wrap = tc && (idx == I_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (tc) begin
         presc <= '0;
         idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Active contents only change at the frame wrap, so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_val  <= '0;
         act_dp   <= '0;
         pend_val <= '0;
         pend_dp  <= '0;
         pend     <= 1'b0;
      end else if (wrap) begin
         pend <= 1'b0;
         if (bus.load) begin
            act_val <= bus.value;
            act_dp  <= bus.dp_in;
         end else if (pend) begin
            act_val <= pend_val;
            act_dp  <= pend_dp;
         end
      end else if (bus.load) begin
         pend_val <= bus.value;
         pend_dp  <= bus.dp_in;
         pend     <= 1'b1;
      end
   end

   always_comb begin
      nib    = '0;
      dp_sel = 1'b0;
      an_d   = '0;
      dark   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib     = act_val[4*i +: 4];
            dp_sel  = act_dp[i];
            an_d[i] = 1'b1;
         end
      end
`ifdef LEADING_ZERO_BLANK_EN
      dark = (idx != '0) && (nib == 4'h0) && !dp_sel;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((IW'(i) > idx) && (act_val[4*i +: 4] != 4'h0))
            dark = 1'b0;
      end
`endif
   end

   always_comb begin
      seg_d = '0;
      unique case (nib)
         4'h0: seg_d = 7'b1111110;
         4'h1: seg_d = 7'b0110000;
         4'h2: seg_d = 7'b1101101;
         4'h3: seg_d = 7'b1111001;
         4'h4: seg_d = 7'b0110011;
         4'h5: seg_d = 7'b1011011;
         4'h6: seg_d = 7'b1011111;
         4'h7: seg_d = 7'b1110000;
         4'h8: seg_d = 7'b1111111;
         4'h9: seg_d = 7'b1111011;
         4'hA: seg_d = 7'b1110111;
         4'hB: seg_d = 7'b0011111;
         4'hC: seg_d = 7'b1001110;
         4'hD: seg_d = 7'b0111101;
         4'hE: seg_d = 7'b1001111;
         4'hF: seg_d = 7'b1000111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '0;
         dot_q <= 1'b0;
         an_q  <= '0;
         fd_q  <= 1'b0;
      end else begin
         fd_q <= wrap;
         if (bus.blank) begin
            seg_q <= '0;
            dot_q <= 1'b0;
            an_q  <= '0;
         end else begin
            seg_q <= dark ? 7'b0 : seg_d;
            dot_q <= dp_sel & ~dark;
            an_q  <= an_d;
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dot        = dot_q;
   assign bus.an         = an_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed frames at NUM_DIGITS=4, SCAN_DIV=4.
// Each frame is 16 clocks; outputs are sampled 1 ns after the rising edge.
module tb_hex_display_scanner;
   localparam int ND = 4;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   hex_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

   hex_display_scanner #(
      .NUM_DIGITS(ND),
      .SCAN_DIV  (SD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] seg_tab(input logic [3:0] n);
      case (n)
         4'h0: return 7'h7E;
         4'h1: return 7'h30;
         4'h2: return 7'h6D;
         4'h3: return 7'h79;
         4'h4: return 7'h33;
         4'h5: return 7'h5B;
         4'h6: return 7'h5F;
         4'h7: return 7'h70;
         4'h8: return 7'h7F;
         4'h9: return 7'h7B;
         4'hA: return 7'h77;
         4'hB: return 7'h1F;
         4'hC: return 7'h4E;
         4'hD: return 7'h3D;
         4'hE: return 7'h4F;
         default: return 7'h47;
      endcase
   endfunction

   function automatic logic is_dark(input logic [15:0] v,
                                    input logic [3:0] dp, input int d);
      logic dk;
      dk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && v[4*d +: 4] == 4'h0 && !dp[d] && (v >> (4*(d+1))) == 0)
         dk = 1'b1;
`endif
      return dk;
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] v,
                                          input logic [3:0] dp, input int d);
      if (is_dark(v, dp, d)) return 7'h00;
      return seg_tab(v[4*d +: 4]);
   endfunction

   task automatic check_zero(input string nm);
      check({nm, " an"},  32'(bus.an),  0);
      check({nm, " seg"}, 32'(bus.seg), 0);
      check({nm, " dot"}, 32'(bus.dot), 0);
      check({nm, " fd"},  32'(bus.frame_done), 0);
   endtask

   // Two frames straight out of reset with an empty display.
   task automatic reset_frames(input string nm);
      for (int e = 1; e <= 32; e++) begin
         int d;
         d = ((e - 1) / 4) % 4;
         tick;
         check($sformatf("%s an e%0d", nm, e), 32'(bus.an), 32'(1 << d));
         check($sformatf("%s seg e%0d", nm, e), 32'(bus.seg),
               32'(exp_seg(16'h0, 4'h0, d)));
         check($sformatf("%s fd e%0d", nm, e), 32'(bus.frame_done),
               32'(e % 16 == 0));
      end
   endtask

   // One frame from just after a wrap to the next wrap, with up to two loads.
   task automatic frame(input string nm, input logic [15:0] v,
                        input logic [3:0] dp,
                        input int l1, input logic [15:0] l1v,
                        input logic [3:0] l1d,
                        input int l2, input logic [15:0] l2v,
                        input logic [3:0] l2d);
      for (int s = 0; s < 16; s++) begin
         int d;
         d = s / 4;
         if (s == l1) begin
            bus.load  = 1'b1;
            bus.value = l1v;
            bus.dp_in = l1d;
         end
         if (s == l2) begin
            bus.load  = 1'b1;
            bus.value = l2v;
            bus.dp_in = l2d;
         end
         tick;
         bus.load = 1'b0;
         check($sformatf("%s an s%0d", nm, s), 32'(bus.an), 32'(1 << d));
         check($sformatf("%s seg s%0d", nm, s), 32'(bus.seg),
               32'(exp_seg(v, dp, d)));
         check($sformatf("%s dot s%0d", nm, s), 32'(bus.dot),
               32'(dp[d] & ~is_dark(v, dp, d)));
         check($sformatf("%s fd s%0d", nm, s), 32'(bus.frame_done),
               32'(s == 15));
      end
   endtask

   task automatic blank_test;
      bus.blank = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         if (e == 5) begin
            bus.load  = 1'b1;
            bus.value = 16'h0000;
            bus.dp_in = 4'h0;
         end
         if (e == 21) bus.blank = 1'b0;
         tick;
         bus.load = 1'b0;
         check($sformatf("blk fd e%0d", e), 32'(bus.frame_done),
               32'(e == 16 || e == 32));
         if (e <= 20) begin
            check($sformatf("blk an e%0d", e),  32'(bus.an),  0);
            check($sformatf("blk seg e%0d", e), 32'(bus.seg), 0);
            check($sformatf("blk dot e%0d", e), 32'(bus.dot), 0);
         end else begin
            int d;
            d = (e - 17) / 4;
            check($sformatf("blk an e%0d", e), 32'(bus.an), 32'(1 << d));
            check($sformatf("blk seg e%0d", e), 32'(bus.seg),
                  32'(exp_seg(16'h0, 4'h0, d)));
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.value = '0;
      bus.dp_in = '0;
      bus.blank = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_zero($sformatf("por%0d", i));
      end
      rst = 1'b0;
      reset_frames("por");

      frame("f0", 16'h0000, 4'h0, 2, 16'hFEDC, 4'h0, -1, 16'h0, 4'h0);
      frame("f1", 16'hFEDC, 4'h0, 5, 16'hBA98, 4'h0, -1, 16'h0, 4'h0);
      frame("f2", 16'hBA98, 4'h0, 0, 16'h7654, 4'h0, -1, 16'h0, 4'h0);
      frame("f3", 16'h7654, 4'h0, 3, 16'h3210, 4'h0, -1, 16'h0, 4'h0);
      frame("f4", 16'h3210, 4'h0, 4, 16'h5555, 4'hF, 6, 16'h1234, 4'h0);
      frame("f5", 16'h1234, 4'h0, 15, 16'hABCD, 4'h0, -1, 16'h0, 4'h0);
      frame("f6", 16'hABCD, 4'h0, 1, 16'h0050, 4'b0100, -1, 16'h0, 4'h0);
      frame("f7", 16'h0050, 4'b0100, 3, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
      frame("f8", 16'h0050, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      blank_test;

      bus.load  = 1'b1;
      bus.value = 16'h9999;
      bus.dp_in = 4'hF;
      tick;
      bus.load = 1'b0;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      check_zero("rst2a");
      tick;
      check_zero("rst2b");
      rst = 1'b0;
      reset_frames("rst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
